// File: rtl/pw_digit_scan_ctrl.sv
// pw_digit_scan_ctrl: sequences adjacent digit pairs of a packed candidate
// through a shared external equality comparator. It tracks run lengths and
// digit ordering, reports part-1/part-2 validity, and counts passing results.
module pw_digit_scan_ctrl #(
  parameter int DIGITS = 6,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIGITS*4-1:0]   in_digits,
  output logic [3:0]            cmp_a,
  output logic [3:0]            cmp_b,
  input  logic                  cmp_eq,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_part1,
  output logic                  out_part2,
  output logic                  busy,
  input  logic                  clr,
  output logic [CNT_W-1:0]      cnt_p1,
  output logic [CNT_W-1:0]      cnt_p2
);

  localparam int K_W = $clog2(DIGITS);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

  state_t                state_q, state_d;
  logic [DIGITS*4-1:0]   digits_q, digits_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [K_W-1:0]        k_p1;
  logic [2:0]            run_q, run_d;
  logic                  ge2_q, ge2_d;
  logic                  ex2_q, ex2_d;
  logic                  dec_q, dec_d;
  logic                  part1_q, part1_d;
  logic                  part2_q, part2_d;
  logic [CNT_W-1:0]      cnt_p1_q, cnt_p1_d;
  logic [CNT_W-1:0]      cnt_p2_q, cnt_p2_d;

  // Per-pair working values; only meaningful while scanning.
  logic [2:0]            run_n;
  logic                  ge2_n, ex2_n, dec_n;
  logic                  enter_done;
  logic [3:0]            pair_a, pair_b;

  // Digit 0 is the most significant nibble of the latched candidate.
  logic [3:0] digit_arr [DIGITS];
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_arr[gi] = digits_q[(DIGITS-1-gi)*4 +: 4];
    end
  endgenerate

  assign k_p1   = k_q + K_W'(1);
  assign pair_a = digit_arr[k_q];
  assign pair_b = digit_arr[k_p1];

  // Next-state, datapath updates and handshake outputs of the scan FSM.
  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    k_d        = k_q;
    run_d      = run_q;
    ge2_d      = ge2_q;
    ex2_d      = ex2_q;
    dec_d      = dec_q;
    part1_d    = part1_q;
    part2_d    = part2_q;
    run_n      = run_q;
    ge2_n      = ge2_q;
    ex2_n      = ex2_q;
    dec_n      = dec_q;
    enter_done = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    cmp_a      = 4'd0;
    cmp_b      = 4'd0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          digits_d = in_digits;
          k_d      = '0;
          run_d    = 3'd1;
          ge2_d    = 1'b0;
          ex2_d    = 1'b0;
          dec_d    = 1'b0;
          state_d  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        cmp_a = pair_a;
        cmp_b = pair_b;
        dec_n = dec_q | (pair_b < pair_a);
        if (cmp_eq) begin
          run_n = (run_q == 3'd7) ? 3'd7 : run_q + 3'd1;
        end else begin
          ge2_n = ge2_q | (run_q >= 3'd2);
          ex2_n = ex2_q | (run_q == 3'd2);
          run_n = 3'd1;
        end
        if (k_q == K_W'(DIGITS-2)) begin
          // Final pair: close the run still open at the least significant end.
          ge2_n      = ge2_n | (run_n >= 3'd2);
          ex2_n      = ex2_n | (run_n == 3'd2);
          part1_d    = ge2_n & ~dec_n;
          part2_d    = ex2_n & ~dec_n;
          enter_done = 1'b1;
          state_d    = ST_DONE;
        end else begin
          k_d = k_p1;
        end
        run_d = run_n;
        ge2_d = ge2_n;
        ex2_d = ex2_n;
        dec_d = dec_n;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          part1_d = 1'b0;
          part2_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Saturating pass counters; clear takes priority over an increment.
  always_comb begin
    cnt_p1_d = cnt_p1_q;
    cnt_p2_d = cnt_p2_q;
    if (enter_done && part1_d && (cnt_p1_q != {CNT_W{1'b1}})) begin
      cnt_p1_d = cnt_p1_q + CNT_W'(1);
    end
    if (enter_done && part2_d && (cnt_p2_q != {CNT_W{1'b1}})) begin
      cnt_p2_d = cnt_p2_q + CNT_W'(1);
    end
    if (clr) begin
      cnt_p1_d = '0;
      cnt_p2_d = '0;
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      digits_q <= '0;
      k_q      <= '0;
      run_q    <= 3'd1;
      ge2_q    <= 1'b0;
      ex2_q    <= 1'b0;
      dec_q    <= 1'b0;
      part1_q  <= 1'b0;
      part2_q  <= 1'b0;
      cnt_p1_q <= '0;
      cnt_p2_q <= '0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      k_q      <= k_d;
      run_q    <= run_d;
      ge2_q    <= ge2_d;
      ex2_q    <= ex2_d;
      dec_q    <= dec_d;
      part1_q  <= part1_d;
      part2_q  <= part2_d;
      cnt_p1_q <= cnt_p1_d;
      cnt_p2_q <= cnt_p2_d;
    end
  end

  assign out_part1 = part1_q;
  assign out_part2 = part2_q;
  assign busy      = (state_q != ST_IDLE);
  assign cnt_p1    = cnt_p1_q;
  assign cnt_p2    = cnt_p2_q;

endmodule

// File: tb/tb_pw_digit_scan_ctrl.sv
// Testbench for pw_digit_scan_ctrl: directed vectors with literal results,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pw_digit_scan_ctrl;

  localparam int DIGITS = 6;
  localparam int CNT_W  = 16;
  localparam int DW     = DIGITS * 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              clr = 1'b0;
  logic [DW-1:0]     in_digits = '0;

  logic              in_ready, out_valid, out_part1, out_part2, busy, cmp_eq;
  logic [3:0]        cmp_a, cmp_b;
  logic [CNT_W-1:0]  cnt_p1, cnt_p2;

  // Narrow-counter twin used to exercise saturation.
  logic              s_in_ready, s_out_valid, s_out_part1, s_out_part2, s_busy, s_cmp_eq;
  logic [3:0]        s_cmp_a, s_cmp_b;
  logic [1:0]        s_cnt_p1, s_cnt_p2;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  assign cmp_eq   = (cmp_a == cmp_b);
  assign s_cmp_eq = (s_cmp_a == s_cmp_b);

  pw_digit_scan_ctrl #(.DIGITS(DIGITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_digits(in_digits), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_eq(cmp_eq),
    .out_valid(out_valid), .out_ready(out_ready), .out_part1(out_part1),
    .out_part2(out_part2), .busy(busy), .clr(clr), .cnt_p1(cnt_p1), .cnt_p2(cnt_p2)
  );

  pw_digit_scan_ctrl #(.DIGITS(DIGITS), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_digits(in_digits), .cmp_a(s_cmp_a), .cmp_b(s_cmp_b), .cmp_eq(s_cmp_eq),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_part1(s_out_part1),
    .out_part2(s_out_part2), .busy(s_busy), .clr(clr), .cnt_p1(s_cnt_p1), .cnt_p2(s_cnt_p2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] dig(input logic [DW-1:0] c, input int i);
    return c[(DIGITS-1-i)*4 +: 4];
  endfunction

  // Rules from the password definition: group equal neighbours, look for
  // any group of >=2 / exactly 2, and reject any descending step.
  function automatic logic [1:0] score(input logic [DW-1:0] c);
    int   len;
    logic dec, ge2, ex2;
    dec = 1'b0; ge2 = 1'b0; ex2 = 1'b0; len = 1;
    for (int i = 1; i < DIGITS; i++) begin
      if (dig(c, i) < dig(c, i-1)) dec = 1'b1;
      if (dig(c, i) == dig(c, i-1)) begin
        len++;
      end else begin
        if (len >= 2) ge2 = 1'b1;
        if (len == 2) ex2 = 1'b1;
        len = 1;
      end
    end
    if (len >= 2) ge2 = 1'b1;
    if (len == 2) ex2 = 1'b1;
    return {ge2 & ~dec, ex2 & ~dec};
  endfunction

  // Behavioural model: 0 = waiting, 1 = scanning pair m_k, 2 = holding result.
  int               m_phase;
  int               m_k;
  logic [DW-1:0]    m_cand;
  logic             m_p1, m_p2;
  logic [CNT_W-1:0] m_c1, m_c2;
  logic [1:0]       m_s1, m_s2;
  logic             m_enter;

  assign m_enter = (m_phase == 1) && (m_k == DIGITS-2);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_k <= 0; m_cand <= '0; m_p1 <= 1'b0; m_p2 <= 1'b0;
      m_c1 <= '0; m_c2 <= '0; m_s1 <= '0; m_s2 <= '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_cand <= in_digits;
          {m_p1, m_p2} <= score(in_digits);
          m_k <= 0;
          m_phase <= 1;
        end
        1: if (m_enter) m_phase <= 2; else m_k <= m_k + 1;
        default: if (out_ready) begin
          m_phase <= 0;
          $display("txn digits=%h part1=%0d part2=%0d cnt_p1=%0d cnt_p2=%0d",
                   m_cand, m_p1, m_p2, m_c1, m_c2);
        end
      endcase
      if (clr) begin
        m_c1 <= '0; m_c2 <= '0; m_s1 <= '0; m_s2 <= '0;
      end else if (m_enter) begin
        if (m_p1 && m_c1 != {CNT_W{1'b1}}) m_c1 <= m_c1 + 1'b1;
        if (m_p2 && m_c2 != {CNT_W{1'b1}}) m_c2 <= m_c2 + 1'b1;
        if (m_p1 && m_s1 != 2'b11) m_s1 <= m_s1 + 1'b1;
        if (m_p2 && m_s2 != 2'b11) m_s2 <= m_s2 + 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  in_ready,  m_phase == 0);
      chk("busy",      busy,      m_phase != 0);
      chk("out_valid", out_valid, m_phase == 2);
      chk("cmp_a",     cmp_a,     (m_phase == 1) ? dig(m_cand, m_k)   : 4'd0);
      chk("cmp_b",     cmp_b,     (m_phase == 1) ? dig(m_cand, m_k+1) : 4'd0);
      chk("out_part1", out_part1, (m_phase == 2) ? m_p1 : 1'b0);
      chk("out_part2", out_part2, (m_phase == 2) ? m_p2 : 1'b0);
      chk("cnt_p1",    cnt_p1,    m_c1);
      chk("cnt_p2",    cnt_p2,    m_c2);
      chk("sat_cnt_p1", s_cnt_p1, m_s1);
      chk("sat_cnt_p2", s_cnt_p2, m_s2);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #2; n++;
    end
    chk("ready_timeout", in_ready, 1'b1);
  endtask

  // One directed candidate with literal expectations, optional DONE stall
  // and optional clear on the edge that enters DONE.
  task automatic send(input logic [DW-1:0] d, input logic l1, input logic l2,
                      input int hold, input logic clr_done);
    int lat;
    wait_ready();
    in_valid = 1'b1; in_digits = d;
    @(posedge clk); #2;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (clr_done && lat == DIGITS-2) clr = 1'b1;
      @(posedge clk); #2;
      clr = 1'b0;
      lat++;
    end
    chk("latency", lat, DIGITS-1);
    chk("lit_part1", out_part1, l1);
    chk("lit_part2", out_part2, l2);
    for (int h = 0; h < hold; h++) begin
      if (h == 0) begin in_valid = 1'b1; in_digits = 24'h999999; end
      @(posedge clk); #2;
      in_valid = 1'b0;
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_part1", out_part1, l1);
      chk("hold_part2", out_part2, l2);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
    chk("back_idle", in_ready, 1'b1);
  endtask

  function automatic logic [DW-1:0] gen();
    logic [DW-1:0] c;
    int v;
    c = '0;
    v = $urandom_range(0, 3);
    for (int i = 0; i < DIGITS; i++) begin
      if ($urandom_range(0, 2) == 0) v = $urandom_range(0, 15);
      else v = (v + $urandom_range(0, 1) > 15) ? 15 : v + $urandom_range(0, 1);
      c[(DIGITS-1-i)*4 +: 4] = v[3:0];
    end
    return c;
  endfunction

  initial begin
    #1 rst = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #2;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_cnt_p1", cnt_p1, 0);
    rst = 1'b0;
    @(posedge clk); #2;

    send(24'h111122, 1'b1, 1'b1, 0, 1'b0);
    send(24'h123444, 1'b1, 1'b0, 3, 1'b0);
    send(24'h112233, 1'b1, 1'b1, 0, 1'b0);
    send(24'h223450, 1'b0, 1'b0, 0, 1'b0);
    send(24'h123789, 1'b0, 1'b0, 0, 1'b0);
    chk("lit_cnt_p1", cnt_p1, 3);
    chk("lit_cnt_p2", cnt_p2, 2);
    chk("lit_sat_p1", s_cnt_p1, 3);

    // Reset in the middle of a scan, at pair k=2.
    wait_ready();
    in_valid = 1'b1; in_digits = 24'h111122;
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_cnt_p1", cnt_p1, 0);
    chk("arst_cnt_p2", cnt_p2, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    send(24'h111111, 1'b1, 1'b0, 0, 1'b0);

    // Clear on the same edge a passing result lands.
    send(24'h111122, 1'b1, 1'b1, 0, 1'b1);
    chk("clr_cnt_p1", cnt_p1, 0);
    chk("clr_cnt_p2", cnt_p2, 0);

    // Saturation of the narrow counters.
    for (int i = 0; i < 4; i++) send(24'h111111, 1'b1, 1'b0, 0, 1'b0);
    chk("sat_hold_p1", s_cnt_p1, 3);
    chk("wide_cnt_p1", cnt_p1, 4);

    // Randomized traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_digits = gen();
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 99) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      @(posedge clk); #2;
    end
    in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0; rst = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
